// File: rtl/key_search_pkg.sv
// Shared types and default sizes for the key_search rule-matching stage.
package key_search_pkg;

  localparam int DEF_RULE_WIDTH = 24;
  localparam int DEF_NUM_RULES  = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_IDX_WIDTH  = $clog2(DEF_NUM_RULES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic                      match;
    logic [DEF_IDX_WIDTH-1:0]  index;
    logic [DEF_RULE_WIDTH-1:0] key;
  } result_t;

  function automatic logic rule_hit(input logic                      valid,
                                    input logic [DEF_RULE_WIDTH-1:0] rule,
                                    input logic [DEF_RULE_WIDTH-1:0] key);
    return valid && (rule == key);
  endfunction

endpackage

// File: rtl/key_search_sync_fifo.sv
// Synchronous FIFO with occupancy count; the caller never pushes when full
// without popping in the same cycle, nor pops when empty.
module sync_fifo #(
  parameter int W = 24,
  parameter int D = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [W-1:0]         data_i,
  output logic [W-1:0]         data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [$clog2(D):0]   count_o
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(D));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/key_search.sv
// Queues incoming keys and scans a register rule table one entry per cycle,
// reporting the lowest matching index for each key.
module key_search
  import key_search_pkg::*;
#(
  parameter int C_RULE_WIDTH = DEF_RULE_WIDTH,
  parameter int C_NUM_RULES  = DEF_NUM_RULES,
  parameter int C_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           search_i,
  input  logic [C_RULE_WIDTH-1:0]        key_i,
  input  logic                           wr_en_i,
  input  logic [$clog2(C_NUM_RULES)-1:0] wr_addr_i,
  input  logic [C_RULE_WIDTH-1:0]        wr_rule_i,
  input  logic                           wr_valid_i,
  output logic                           res_valid_o,
  output logic                           res_match_o,
  output logic [$clog2(C_NUM_RULES)-1:0] res_index_o,
  output logic [C_RULE_WIDTH-1:0]        res_key_o,
  output logic                           busy_o,
  output logic                           ovf_o
);

  localparam int IW = $clog2(C_NUM_RULES);
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

  logic [C_RULE_WIDTH-1:0] rule_q [C_NUM_RULES];
  logic [C_NUM_RULES-1:0]  valid_q;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [C_RULE_WIDTH-1:0] cur_key_q, cur_key_d;
  result_t                 res_q, res_d;
  logic                    res_valid_q, res_valid_d;
  logic                    ovf_q, ovf_d;

  logic                    fifo_push_s;
  logic                    fifo_pop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [C_RULE_WIDTH-1:0] fifo_head_s;
  logic [CW-1:0]           fifo_count_s;
  logic                    hit_s;

  sync_fifo #(
    .W (C_RULE_WIDTH),
    .D (C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .data_i  (key_i),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // A full FIFO still accepts a key when the head leaves in the same cycle.
  always_comb begin
    fifo_pop_s  = (state_q == IDLE) && !fifo_empty_s;
    fifo_push_s = search_i && (!fifo_full_s || fifo_pop_s);
    ovf_d       = ovf_q | (search_i & fifo_full_s & ~fifo_pop_s);
  end

  assign hit_s = rule_hit(valid_q[idx_q], rule_q[idx_q], cur_key_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_key_d   = cur_key_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          cur_key_d = fifo_head_s;
          idx_d     = {IW{1'b0}};
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (hit_s) begin
          res_valid_d = 1'b1;
          res_d       = '{match: 1'b1, index: idx_q, key: cur_key_q};
          state_d     = IDLE;
        end else if (idx_q == IW'(C_NUM_RULES - 1)) begin
          res_valid_d = 1'b1;
          res_d       = '{match: 1'b0, index: {IW{1'b0}}, key: cur_key_q};
          state_d     = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= {IW{1'b0}};
      cur_key_q   <= {C_RULE_WIDTH{1'b0}};
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_key_q   <= cur_key_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Compares read the pre-edge table, so a same-cycle write is seen next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= {C_NUM_RULES{1'b0}};
    end else if (wr_en_i) begin
      valid_q[wr_addr_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      rule_q[wr_addr_i] <= wr_rule_i;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_match_o = res_q.match;
  assign res_index_o = res_q.index;
  assign res_key_o   = res_q.key;
  assign busy_o      = (state_q != IDLE) || (fifo_count_s != {CW{1'b0}});
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_key_search.sv
// Scoreboard bench for key_search: a cycle-indexed behavioural model predicts
// each result and its strobe cycle; a negedge monitor pops and compares.
module tb_key_search;
  import key_search_pkg::*;

  localparam int RW = 24;
  localparam int NR = 16;
  localparam int FD = 8;
  localparam int IW = $clog2(NR);

  logic          clk_i = 1'b0;
  logic          rst_i, search_i, wr_en_i, wr_valid_i;
  logic [RW-1:0] key_i, wr_rule_i;
  logic [IW-1:0] wr_addr_i;
  logic          res_valid_o, res_match_o, busy_o, ovf_o;
  logic [IW-1:0] res_index_o;
  logic [RW-1:0] res_key_o;

  always #5 clk_i = ~clk_i;

  key_search dut (
    .clk_i(clk_i), .rst_i(rst_i), .search_i(search_i), .key_i(key_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_rule_i(wr_rule_i),
    .wr_valid_i(wr_valid_i), .res_valid_o(res_valid_o), .res_match_o(res_match_o),
    .res_index_o(res_index_o), .res_key_o(res_key_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  typedef struct {
    int            cyc;
    logic          match;
    logic [IW-1:0] idx;
    logic [RW-1:0] key;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   strobes = 0;
  int   last_strobe = -1;

  // Reference model state
  logic [RW-1:0] m_rule [NR];
  bit            m_valid [NR];
  logic [RW-1:0] m_pend[$];
  bit            m_inflight = 1'b0;
  logic [RW-1:0] m_cur;
  int            m_pop_cyc;
  bit            m_ovf = 1'b0;
  bit            exp_busy = 1'b0;
  bit            exp_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timing rules: a key popped in cycle p compares entry i in cycle p+1+i and
  // its result strobes the cycle after the deciding compare.
  task automatic model_step();
    bit was_inflight;
    int i;
    exp_busy = (m_pend.size() > 0) || m_inflight;
    exp_ovf  = m_ovf;
    if (rst_i) begin
      m_pend.delete();
      m_inflight = 1'b0;
      m_ovf      = 1'b0;
      foreach (m_valid[j]) m_valid[j] = 1'b0;
    end else begin
      was_inflight = m_inflight;
      if (m_inflight) begin
        i = cyc - m_pop_cyc - 1;
        if (m_valid[i] && (m_rule[i] == m_cur)) begin
          sb.push_back('{cyc + 1, 1'b1, IW'(i), m_cur});
          m_inflight = 1'b0;
        end else if (i == NR - 1) begin
          sb.push_back('{cyc + 1, 1'b0, {IW{1'b0}}, m_cur});
          m_inflight = 1'b0;
        end
      end
      if (!was_inflight && (m_pend.size() > 0)) begin
        m_cur      = m_pend.pop_front();
        m_pop_cyc  = cyc;
        m_inflight = 1'b1;
      end
      if (search_i) begin
        if (m_pend.size() < FD) m_pend.push_back(key_i);
        else m_ovf = 1'b1;
      end
      if (wr_en_i) begin
        m_rule[wr_addr_i]  = wr_rule_i;
        m_valid[wr_addr_i] = wr_valid_i;
      end
    end
  endtask

  task automatic tick(input bit rst, input bit srch, input logic [RW-1:0] key,
                      input bit we = 1'b0, input logic [IW-1:0] wa = 4'd0,
                      input logic [RW-1:0] wr = 24'd0, input bit wv = 1'b0);
    rst_i = rst; search_i = srch; key_i = key;
    wr_en_i = we; wr_addr_i = wa; wr_rule_i = wr; wr_valid_i = wv;
    if (mon_en) model_step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() > 0 || m_inflight || m_pend.size() > 0) && n < 300) begin
      tick(1'b0, 1'b0, 24'd0);
      n++;
    end
    if (n >= 300) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: strobes against the scoreboard, held fields, busy and ovf.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    exp_t last;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missed_strobe", 32'd0, 32'd1);
      end
      if (res_valid_o === 1'b1) begin
        strobes++;
        last_strobe = cyc;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("res_match", 32'(res_match_o), 32'(e.match));
          chk("res_index", 32'(res_index_o), 32'(e.idx));
          chk("res_key", 32'(res_key_o), 32'(e.key));
          last = e;
        end
      end else begin
        chk("res_valid_low", 32'(res_valid_o), 32'd0);
        chk("res_hold", {7'd0, res_match_o, res_key_o},
            {7'd0, last.match, last.key});
        chk("res_hold_index", 32'(res_index_o), 32'(last.idx));
      end
      chk("busy", 32'(busy_o), 32'(exp_busy));
      chk("ovf", 32'(ovf_o), 32'(exp_ovf));
      if (rst_i) last = '{0, 1'b0, {IW{1'b0}}, {RW{1'b0}}};
    end
  end

  initial begin : stim
    int c0;
    int s0;
    rst_i = 1'b1; search_i = 1'b0; key_i = '0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_rule_i = '0; wr_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_res_valid", 32'(res_valid_o), 32'd0);
    chk("reset_res_fields", {7'd0, res_match_o, res_key_o}, 32'd0);
    chk("reset_res_index", 32'(res_index_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_ovf", 32'(ovf_o), 32'd0);
    mon_en = 1'b1;
    tick(1'b1, 1'b0, 24'd0);

    // Hit at index 5: strobe 8 cycles after the push
    tick(1'b0, 1'b0, 24'd0, 1'b1, 4'd5, 24'h010155, 1'b1);
    c0 = cyc;
    tick(1'b0, 1'b1, 24'h010155);
    wait_idle();
    chk("t1_latency", 32'(last_strobe - c0), 32'd8);
    chk("t1_index", 32'(res_index_o), 32'd5);

    // Lowest of two matching entries wins
    tick(1'b0, 1'b0, 24'd0, 1'b1, 4'd3, 24'h010107, 1'b1);
    tick(1'b0, 1'b0, 24'd0, 1'b1, 4'd9, 24'h010107, 1'b1);
    tick(1'b0, 1'b1, 24'h010107);
    wait_idle();
    chk("t2_index", 32'(res_index_o), 32'd3);
    chk("t2_match", 32'(res_match_o), 32'd1);

    // Full-table miss
    c0 = cyc;
    tick(1'b0, 1'b1, 24'h0101AA);
    wait_idle();
    chk("t3_latency", 32'(last_strobe - c0), 32'd18);
    chk("t3_match", 32'(res_match_o), 32'd0);

    // Burst of 12 misses into a depth-8 FIFO
    tick(1'b1, 1'b0, 24'd0);
    s0 = strobes;
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 24'h010100 + 24'(i));
      chk("t4_ovf_onset", 32'(ovf_o), 32'((cyc - c0) >= 10));
    end
    wait_idle();
    chk("t4_strobes", 32'(strobes - s0), 32'd9);
    chk("t4_ovf_sticky", 32'(ovf_o), 32'd1);

    // Reset mid-scan with three keys queued
    tick(1'b1, 1'b0, 24'd0);
    c0 = cyc;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 24'h0A0A00 + 24'(i));
    tick(1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 24'd0);
    chk("t5_reset_cycle", 32'(cyc - c0), 32'd6);
    tick(1'b1, 1'b0, 24'd0);
    s0 = strobes;
    repeat (20) tick(1'b0, 1'b0, 24'd0);
    chk("t5_no_strobe", 32'(strobes - s0), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_ovf", 32'(ovf_o), 32'd0);
    tick(1'b0, 1'b0, 24'd0, 1'b1, 4'd1, 24'h0A0A0A, 1'b1);
    c0 = cyc;
    tick(1'b0, 1'b1, 24'h0A0A0A);
    wait_idle();
    chk("t5_latency", 32'(last_strobe - c0), 32'd4);

    // Write landing in the same cycle as the compare of that index
    tick(1'b1, 1'b0, 24'd0);
    tick(1'b0, 1'b1, 24'h010120);
    repeat (3) tick(1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 24'd0, 1'b1, 4'd2, 24'h010120, 1'b1);
    wait_idle();
    chk("t6_old_contents", 32'(res_match_o), 32'd0);
    tick(1'b0, 1'b1, 24'h010120);
    wait_idle();
    chk("t6_new_match", 32'(res_match_o), 32'd1);
    chk("t6_new_index", 32'(res_index_o), 32'd2);

    // Random traffic, table writes and occasional resets
    tick(1'b1, 1'b0, 24'd0);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 399) == 0);
      tick(r, ($urandom_range(0, 2) == 0), 24'h0A0000 + 24'($urandom_range(0, 7)),
           (!r && $urandom_range(0, 5) == 0), 4'($urandom_range(0, NR - 1)),
           24'h0A0000 + 24'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    wait_idle();
    chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_search.md
# key_search

Rule-matching stage directly downstream of the test key generator. Every cycle with `search_i` high, it accepts a 24-bit key into an input FIFO. It then scans a small register-based rule table sequentially, one entry per cycle, and reports whether the key matched, at which index, and which key was searched. The FIFO absorbs back-to-back key bursts, and a sticky flag records any dropped keys.

## Interface
- `C_RULE_WIDTH`, 24: key/rule width in bits.
- `C_NUM_RULES`, 16: table entries, ≥2; index width `IW = $clog2(C_NUM_RULES)`.
- `C_FIFO_DEPTH`, 8: input FIFO depth, power of two, ≥2.

- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `search_i` in 1: key valid; one key accepted per cycle while high.
- `key_i` in C_RULE_WIDTH: key, sampled when `search_i`=1.
- `wr_en_i` in 1: table write strobe.
- `wr_addr_i` in IW: table write index.
- `wr_rule_i` in C_RULE_WIDTH: rule value written.
- `wr_valid_i` in 1: entry valid bit written with the rule.
- `res_valid_o` out 1: one-cycle result strobe.
- `res_match_o` out 1: 1 = hit.
- `res_index_o` out IW: lowest matching index; 0 on miss.
- `res_key_o` out C_RULE_WIDTH: key the result refers to.
- `busy_o` out 1: FSM not IDLE, or FIFO not empty.
- `ovf_o` out 1: sticky; a key was dropped on a full FIFO.

## Operation
- Reset clears:
  - all outputs to 0;
  - FIFO pointers and count;
  - all table valid bits;
  - FSM to IDLE.
- Table rule values are not reset.
- FIFO push:
  - Occurs on `search_i`=1 when not full, or when full and a pop happens in the same cycle.
  - A push on full without a pop drops the key and sets `ovf_o`.
  - Pointers wrap modulo `C_FIFO_DEPTH`.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states are IDLE, SCAN.
  - IDLE: if the FIFO is not empty, pop the head into `cur_key`, set `idx`=0, go to SCAN.
  - SCAN: compare `valid[idx] && rule[idx]==cur_key`.
    - Hit: register a result with match=1 and index=`idx`; go to IDLE.
    - Miss at `idx`=C_NUM_RULES-1: register a result with match=0 and index=0; go to IDLE.
    - Otherwise: `idx`+1.
- First match wins: the scan stops at the lowest matching index.
- `res_*_o` are registered. `res_valid_o` is high for exactly one cycle per popped key. `res_match_o`, `res_index_o` and `res_key_o` hold until the next result.
- Table write:
  - Takes effect at the clock edge.
  - A compare in the same cycle as a write to the same index uses the old contents.
  - Writes are allowed in any state.

## Timing
- Key pushed in cycle 0 into an empty FIFO:
  - Pop in cycle 1 (IDLE).
  - Compare of `idx` 0 in cycle 2.
  - Hit at index k gives `res_valid_o` in cycle 3+k.
  - Miss gives `res_valid_o` in cycle C_NUM_RULES+2.
- Per-key occupancy is k+2 cycles (hit) or C_NUM_RULES+1 cycles (miss). The IDLE pop cycle is always spent, so there is no back-to-back scan.
- `busy_o` rises the cycle after the first push. It falls in the cycle the last result is strobed.
- `rst_i` mid-scan:
  - The scan is abandoned with no result strobe.
  - Queued keys are discarded.
  - `ovf_o` is cleared.
  - Operation resumes on the first cycle after `rst_i` falls.
- There is no backpressure on results: the consumer must accept every strobe.

## Structure
- Package `key_search_pkg`:
  - default `C_RULE_WIDTH`;
  - `state_t` enum {IDLE, SCAN};
  - `result_t` packed struct {match, index, key}.
- Sub-module `sync_fifo`:
  - parameterised width/depth;
  - push/pop/full/empty/count;
  - synchronous active-high reset.
  - The drop/ovf logic stays in `key_search`.
- The table is a register array plus a valid-bit vector in the top module. No RAM inference is needed.

## Test plan
- Write rule 0x010155 at index 5 (valid); push key 0x010155 at cycle 0.
  - Expect `res_valid_o` at cycle 8 with match=1, index=5, key=0x010155.
- Rules 0x010107 at indices 3 and 9; push 0x010107.
  - Expect match=1, index=3 (lowest wins).
- Push 0x0101AA with no matching entry (C_NUM_RULES=16).
  - Expect `res_valid_o` at cycle 18 with match=0, index=0.
- Burst of 12 consecutive `search_i` cycles with keys 0x010100..0x01010B, all misses, depth 8:
  - Keys 0..8 produce results in order (one popped at cycle 1, eight queued).
  - Keys 9..11 are dropped; `ovf_o`=1 from cycle 10 and stays high.
  - Exactly 9 strobes.
- Start a scan, then assert `rst_i` at cycle 6 with 3 keys queued.
  - No `res_valid_o` follows.
  - `busy_o`=0 and `ovf_o`=0 after reset.
  - A new key pushed after reset gives normal latency.
- While scanning key 0x010120, write 0x010120 valid to index 2 in the same cycle that `idx`=2 is compared.
  - Expect a miss (old contents used).
  - Repeat the key: hit at index 2.
